sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Single-port access sequencer for the 128 x 256-bit SRAM array. It accepts one read or write request at a time over a valid/ready handshake. It drives the bitline precharge, the row address and row-decoder enable (`en_pcomp`), the write drivers and the sense-amp enable in a fixed timed sequence. It returns read data, or write completion, as a one-cycle response pulse. It sits directly upstream of the 7-to-128 row decoder: `row_addr` feeds the decoder `addr`, and `en_pcomp` feeds the decoder `en_pcomp`.

## Interface
- PRE_CYCLES, 2: cycles of bitline precharge; must be >= 1
- WL_CYCLES, 1: cycles of wordline settle before sense/write; must be >= 1
- SENSE_CYCLES, 1: cycles of sense-amp enable; must be >= 1
- WRITE_CYCLES, 2: cycles of write-driver enable; must be >= 1
- clk  in  1  sole clock, all flops rising-edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  7  row address
- req_wdata  in  256  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  256  read data, valid while rsp_valid is high after a read
- row_addr  out  7  row address to the row decoder
- en_pcomp  out  1  row-decoder enable; the wordline is active only while this is high
- pre_en  out  1  bitline precharge enable
- wdrv_en  out  1  write-driver enable
- wdrv_data  out  256  write-driver data
- sae  out  1  sense-amp enable
- sa_data  in  256  sense-amp outputs

## Operation
- FSM states: IDLE, PRECH, WL, SENSE, WRITE, RESP. A down-counter times each multi-cycle state.
- Outputs:
  - Every output except req_ready is a flop, or is decoded from registered state only. No input-to-output combinational path exists except through req_ready.
  - req_ready = (state == IDLE) && rst_n.
- IDLE
  - Accept when req_valid && req_ready.
  - At acceptance, latch req_addr into row_addr, req_we into an internal we flag, and req_wdata into wdrv_data.
  - Next state is PRECH.
  - Requests in any other state are not accepted; the requester holds them.
- PRECH: pre_en = 1 for PRE_CYCLES cycles, with en_pcomp = 0. Next state is WL.
- WL: en_pcomp = 1 for WL_CYCLES cycles. Next state is SENSE if we = 0, otherwise WRITE.
- SENSE
  - en_pcomp = 1 and sae = 1 for SENSE_CYCLES cycles.
  - sa_data is captured into rsp_rdata at the clock edge that ends the last SENSE cycle.
  - Next state is RESP.
- WRITE: en_pcomp = 1 and wdrv_en = 1 for WRITE_CYCLES cycles. Next state is RESP.
- RESP: rsp_valid = 1 for exactly one cycle, with all array enables 0. Next state is IDLE.
- There is no response back-pressure. The consumer must take rsp_valid when it pulses.
- Invariants:
  - pre_en && en_pcomp is never true.
  - sae && wdrv_en is never true.
  - pre_en is never high in the same cycle as sae or wdrv_en.
- row_addr is stable from the cycle after acceptance through RESP. It holds its value in IDLE until the next acceptance.
- rsp_rdata holds its value until the next read capture. A write does not modify it.

## Timing
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - pre_en, en_pcomp, sae, wdrv_en and rsp_valid = 0.
  - row_addr = 0, rsp_rdata = 0, wdrv_data = 0.
  - req_ready = 0 while rst_n is low, and 1 in the first cycle after release.
- Reset mid-operation: at the next edge all enables drop to 0 and state returns to IDLE. The in-flight transaction is discarded and no rsp_valid is issued.
- Cycle numbering: cycle 0 is the cycle in which the handshake occurs. PRECH occupies cycles 1..PRE.
- Read latency: rsp_valid is high in cycle PRE+WL+SENSE+1. With default parameters this is cycle 5.
- Write latency: rsp_valid is high in cycle PRE+WL+WRITE+1. With default parameters this is cycle 6.
- A request held valid during RESP is accepted in the following IDLE cycle. Peak read throughput is therefore one request per PRE+WL+SENSE+2 cycles (6 with default parameters).
- Counter width is sized to the largest parameter value. Each state lasts exactly its parameter count; there is no off-by-one padding.

## Test plan
- Reset: hold rst_n low for 3 cycles while req_valid = 1. Required: no acceptance, all outputs at their reset values, and req_ready = 1 in the first cycle after release.
- Single write: addr 7'h55, wdata = {8{32'hA5A5_0F0F}}, defaults. Required:
  - pre_en high in cycles 1-2.
  - en_pcomp high in cycles 3-5.
  - wdrv_en high in cycles 4-5, with wdrv_data equal to the write data.
  - row_addr = 7'h55 throughout.
  - rsp_valid high in cycle 6 only.
- Single read: addr 7'h7F, with sa_data = 256'h1234…(pattern) driven in cycle 4. Required:
  - sae high in cycle 4 only.
  - rsp_valid high in cycle 5 with rsp_rdata equal to the pattern.
  - The following write leaves rsp_rdata unchanged.
- Back-to-back: req_valid held high with 4 queued reads (addr 0, 1, 126, 127). Required: acceptances in cycles 0, 6, 12 and 18, and no overlap of pre_en with en_pcomp in any cycle.
- Mid-operation reset: assert rst_n low in cycle 4 of a write. Required: at the next edge wdrv_en = en_pcomp = 0, no rsp_valid is ever issued, and the next request completes normally.
- Parameter sweep: PRE = 1, WL = 3, SENSE = 2. Required: read rsp_valid in cycle 7. The invariants hold on every cycle, checked by assertions.

Source files
------------

// File: rtl/sram_access_ctrl.sv
// Single-port access sequencer for a 128 x 256-bit SRAM array: precharge, wordline
// settle, then sense or write, followed by a one-cycle response pulse.
module sram_access_ctrl #(
  parameter int PRE_CYCLES   = 2,
  parameter int WL_CYCLES    = 1,
  parameter int SENSE_CYCLES = 1,
  parameter int WRITE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [6:0]   req_addr,
  input  logic [255:0] req_wdata,
  output logic         rsp_valid,
  output logic [255:0] rsp_rdata,
  output logic [6:0]   row_addr,
  output logic         en_pcomp,
  output logic         pre_en,
  output logic         wdrv_en,
  output logic [255:0] wdrv_data,
  output logic         sae,
  input  logic [255:0] sa_data
);

  localparam int MAX_AB = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int MAX_CD = (SENSE_CYCLES > WRITE_CYCLES) ? SENSE_CYCLES : WRITE_CYCLES;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, PRECH, WL, SENSE, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic          accept;
  logic          cnt_done;

  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign cnt_done  = (cnt_q == '0);

  // The counter is loaded with (N-1) on entry so each state lasts exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRECH;
          cnt_d   = CW'(PRE_CYCLES - 1);
        end
      end
      PRECH: begin
        if (cnt_done) begin
          state_d = WL;
          cnt_d   = CW'(WL_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WL: begin
        if (cnt_done) begin
          state_d = we_q ? WRITE : SENSE;
          cnt_d   = we_q ? CW'(WRITE_CYCLES - 1) : CW'(SENSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SENSE, WRITE: begin
        if (cnt_done) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array enables are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      pre_en    <= 1'b0;
      en_pcomp  <= 1'b0;
      sae       <= 1'b0;
      wdrv_en   <= 1'b0;
      rsp_valid <= 1'b0;
      row_addr  <= '0;
      wdrv_data <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_en    <= (state_d == PRECH);
      en_pcomp  <= (state_d == WL) || (state_d == SENSE) || (state_d == WRITE);
      sae       <= (state_d == SENSE);
      wdrv_en   <= (state_d == WRITE);
      rsp_valid <= (state_d == RESP);
      if (accept) begin
        row_addr  <= req_addr;
        we_q      <= req_we;
        wdrv_data <= req_wdata;
      end
      if (state_q == SENSE && cnt_done) begin
        rsp_rdata <= sa_data;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default-parameter instance plus a
// PRE=1/WL=3/SENSE=2 instance sharing clock and reset.
module tb_sram_access_ctrl;

  logic         clk, rst_n;
  logic         req_valid, req_we, req_ready;
  logic [6:0]   req_addr, row_addr;
  logic [255:0] req_wdata, sa_data, rsp_rdata, wdrv_data;
  logic         rsp_valid, en_pcomp, pre_en, wdrv_en, sae;

  logic         p_req_valid, p_req_we, p_req_ready;
  logic [6:0]   p_req_addr, p_row_addr;
  logic [255:0] p_req_wdata, p_sa_data, p_rsp_rdata, p_wdrv_data;
  logic         p_rsp_valid, p_en_pcomp, p_pre_en, p_wdrv_en, p_sae;

  int total = 0;
  int bad   = 0;

  logic [255:0] PAT, WDAT;

  sram_access_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .row_addr(row_addr),
    .en_pcomp(en_pcomp), .pre_en(pre_en), .wdrv_en(wdrv_en),
    .wdrv_data(wdrv_data), .sae(sae), .sa_data(sa_data)
  );

  sram_access_ctrl #(.PRE_CYCLES(1), .WL_CYCLES(3), .SENSE_CYCLES(2), .WRITE_CYCLES(2)) u_par (
    .clk(clk), .rst_n(rst_n), .req_valid(p_req_valid), .req_ready(p_req_ready),
    .req_we(p_req_we), .req_addr(p_req_addr), .req_wdata(p_req_wdata),
    .rsp_valid(p_rsp_valid), .rsp_rdata(p_rsp_rdata), .row_addr(p_row_addr),
    .en_pcomp(p_en_pcomp), .pre_en(p_pre_en), .wdrv_en(p_wdrv_en),
    .wdrv_data(p_wdrv_data), .sae(p_sae), .sa_data(p_sa_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable-exclusivity invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(pre_en && en_pcomp)) else $error("invariant pre_en&&en_pcomp");
      assert (!(sae && wdrv_en)) else $error("invariant sae&&wdrv_en");
      assert (!(pre_en && (sae || wdrv_en))) else $error("invariant pre_en with sae/wdrv_en");
      assert (!(p_pre_en && p_en_pcomp)) else $error("invariant p pre_en&&en_pcomp");
      assert (!(p_sae && p_wdrv_en)) else $error("invariant p sae&&wdrv_en");
      assert (!(p_pre_en && (p_sae || p_wdrv_en))) else $error("invariant p pre_en with sae/wdrv_en");
    end
  end

  // Caller is at a negedge; the following posedge completes the handshake (cycle 0).
  task automatic start_req(input logic we, input logic [6:0] addr, input logic [255:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h3C; req_wdata = '1; sa_data = '1;
    p_req_valid = 1'b0; p_req_we = 1'b0; p_req_addr = '0; p_req_wdata = '0; p_sa_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({req_ready, pre_en, en_pcomp, sae, wdrv_en, rsp_valid} !== 6'b0) begin
        bad++; $display("FAIL reset_ctrl cyc%0d got=%b want=000000", i,
                        {req_ready, pre_en, en_pcomp, sae, wdrv_en, rsp_valid});
      end
    end
    total++;
    if ({row_addr, rsp_rdata, wdrv_data} !== '0) begin
      bad++; $display("FAIL reset_data row=%h rd=%h wd=%h want 0", row_addr, rsp_rdata, wdrv_data);
    end
    rst_n = 1'b1; req_valid = 1'b0; sa_data = '0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
    @(negedge clk);
    total++;
    if ({pre_en, en_pcomp, rsp_valid} !== 3'b0) begin
      bad++; $display("FAIL reset_no_accept got=%b want=000", {pre_en, en_pcomp, rsp_valid});
    end
  endtask

  task automatic test_single_write();
    logic [4:0] exp;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", req_ready); end
    start_req(1'b1, 7'h55, WDAT);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp = {k <= 2, k >= 3 && k <= 5, k == 4 || k == 5, 1'b0, k == 6};
      total++;
      if ({pre_en, en_pcomp, wdrv_en, sae, rsp_valid} !== exp) begin
        bad++; $display("FAIL wr_seq cyc%0d got=%b want=%b", k,
                        {pre_en, en_pcomp, wdrv_en, sae, rsp_valid}, exp);
      end
      total++;
      if (row_addr !== 7'h55) begin
        bad++; $display("FAIL wr_row cyc%0d got=%h want=55", k, row_addr);
      end
      if (k == 4) begin
        total++;
        if (wdrv_data !== WDAT) begin bad++; $display("FAIL wr_data got=%h want=%h", wdrv_data, WDAT); end
      end
    end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_single_read();
    logic [4:0] exp;
    start_req(1'b0, 7'h7F, '0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      exp = {k <= 2, k == 3 || k == 4, k == 4, 1'b0, k == 5};
      total++;
      if ({pre_en, en_pcomp, sae, wdrv_en, rsp_valid} !== exp) begin
        bad++; $display("FAIL rd_seq cyc%0d got=%b want=%b", k,
                        {pre_en, en_pcomp, sae, wdrv_en, rsp_valid}, exp);
      end
      if (k == 4) sa_data = PAT;
      if (k == 5) begin
        total++;
        if (rsp_rdata !== PAT) begin bad++; $display("FAIL rd_data got=%h want=%h", rsp_rdata, PAT); end
        sa_data = ~PAT;
      end
    end
    // A write afterwards must leave the captured read data alone.
    start_req(1'b1, 7'h01, WDAT ^ PAT);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (k == 6) begin
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_then_wr_rsp got=%b want=1", rsp_valid); end
      end
    end
    total++;
    if (rsp_rdata !== PAT) begin bad++; $display("FAIL rd_hold_after_wr got=%h want=%h", rsp_rdata, PAT); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] addrs [4];
    int acc [4];
    int n, overlap, rsp_n;
    addrs[0] = 7'd0; addrs[1] = 7'd1; addrs[2] = 7'd126; addrs[3] = 7'd127;
    for (int i = 0; i < 4; i++) acc[i] = -1;
    n = 0; overlap = 0; rsp_n = 0;
    sa_data = ~PAT;
    req_we = 1'b0;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      if (n < 4) begin req_valid = 1'b1; req_addr = addrs[n]; end
      else req_valid = 1'b0;
      if (pre_en && en_pcomp) overlap++;
      if (rsp_valid) begin
        total++;
        if (rsp_n >= 4 || row_addr !== addrs[rsp_n] || rsp_rdata !== ~PAT) begin
          bad++; $display("FAIL b2b_rsp%0d row=%h rd=%h", rsp_n, row_addr, rsp_rdata);
        end
        rsp_n++;
      end
      if (req_valid && req_ready) begin acc[n] = c; n++; end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc[i] !== 6 * i) begin bad++; $display("FAIL b2b_accept%0d got=%0d want=%0d", i, acc[i], 6 * i); end
    end
    total++;
    if (overlap !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d want=0", overlap); end
    total++;
    if (rsp_n !== 4) begin bad++; $display("FAIL b2b_rsp_count got=%0d want=4", rsp_n); end
  endtask

  task automatic test_mid_reset();
    int rsp_seen, lat;
    logic [255:0] q;
    @(negedge clk);
    start_req(1'b1, 7'h22, WDAT);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({wdrv_en, en_pcomp, pre_en, rsp_valid} !== 4'b0) begin
      bad++; $display("FAIL midrst_enables got=%b want=0000", {wdrv_en, en_pcomp, pre_en, rsp_valid});
    end
    rst_n = 1'b1;
    rsp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    total++;
    if (rsp_seen !== 0) begin bad++; $display("FAIL midrst_no_rsp got=%0d want=0", rsp_seen); end
    q = PAT ^ {8{32'h0F0F_F0F0}};
    sa_data = q;
    start_req(1'b0, 7'h2A, '0);
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (rsp_valid) lat = k;
    end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL midrst_next_latency got=%0d want=5", lat); end
    total++;
    if (rsp_rdata !== q || row_addr !== 7'h2A) begin
      bad++; $display("FAIL midrst_next_data rd=%h row=%h want %h/2a", rsp_rdata, row_addr, q);
    end
  endtask

  task automatic test_param_sweep();
    logic [4:0] exp;
    @(negedge clk);
    total++;
    if (p_req_ready !== 1'b1) begin bad++; $display("FAIL sweep_ready got=%b want=1", p_req_ready); end
    p_sa_data = WDAT ^ PAT;
    p_req_valid = 1'b1; p_req_we = 1'b0; p_req_addr = 7'h03;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) p_req_valid = 1'b0;
      exp = {k == 1, k >= 2 && k <= 6, k == 5 || k == 6, 1'b0, k == 7};
      total++;
      if ({p_pre_en, p_en_pcomp, p_sae, p_wdrv_en, p_rsp_valid} !== exp) begin
        bad++; $display("FAIL sweep_seq cyc%0d got=%b want=%b", k,
                        {p_pre_en, p_en_pcomp, p_sae, p_wdrv_en, p_rsp_valid}, exp);
      end
      if (k == 7) begin
        total++;
        if (p_rsp_rdata !== (WDAT ^ PAT) || p_row_addr !== 7'h03) begin
          bad++; $display("FAIL sweep_data rd=%h row=%h", p_rsp_rdata, p_row_addr);
        end
      end
    end
  endtask

  initial begin
    WDAT = {8{32'hA5A5_0F0F}};
    PAT  = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0FED_CBA9, 32'h8765_4321,
            32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEEF, 32'hC0FF_EE11};
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_mid_reset();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
